// File: rtl/ntr_bus_ctrl_if.sv
// NTR slave-port bundle: cartridge pins plus the command/response handshake.
// The xfer_cnt/err_cnt members exist only when NTR_XFER_STATS_EN is defined.
interface ntr_bus_ctrl_if #(
   parameter int unsigned LEN_W = 13
);
   logic             ntr_clk;
   logic             ntr_cs1;
   logic [7:0]       ntr_din;
   logic [7:0]       ntr_dout;
   logic             ntr_oe;
   logic [63:0]      cmd;
   logic             cmd_valid;
   logic             rsp_ack;
   logic [LEN_W-1:0] rsp_len;
   logic             rd_req;
   logic [7:0]       rd_data;
   logic             abort;
   logic             underrun;
`ifdef NTR_XFER_STATS_EN
   logic [15:0]      xfer_cnt;
   logic [15:0]      err_cnt;
`endif

   modport slave (
      input  ntr_clk, ntr_cs1, ntr_din, rsp_ack, rsp_len, rd_data,
      output ntr_dout, ntr_oe, cmd, cmd_valid, rd_req, abort, underrun
`ifdef NTR_XFER_STATS_EN
      , output xfer_cnt, err_cnt
`endif
   );

   modport master (
      output ntr_clk, ntr_cs1, ntr_din, rsp_ack, rsp_len, rd_data,
      input  ntr_dout, ntr_oe, cmd, cmd_valid, rd_req, abort, underrun
`ifdef NTR_XFER_STATS_EN
      , input xfer_cnt, err_cnt
`endif
   );
endinterface

// File: rtl/ntr_bus_ctrl.sv
// NTR cartridge slave-port sequencer: oversamples ntr_clk/ntr_cs1, captures the 8-byte
// command, then streams rsp_len response bytes. NTR_XFER_STATS_EN adds xfer/err counters.
module ntr_bus_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LEN_W       = 13
) (
   input logic           clk,
   input logic           rst_n,
   ntr_bus_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CMD, WAIT_RSP, DATA, DONE} state_t;

   state_t           state, state_n;
   logic [SYNC_STAGES:0] clk_sync, cs_sync;
   logic             clk_rise, cs_rise, cs_fall;
   logic [63:0]      cmd_q, cmd_n;
   logic             cmd_valid_q, cmd_valid_n;
   logic [2:0]       byte_cnt, byte_cnt_n;
   logic [LEN_W-1:0] cnt, cnt_n, cnt_inc, len, len_n;
   logic [7:0]       dout_q, dout_n;
   logic             oe_q, oe_n, rd_req_q, rd_req_n, load_q, load_n;
   logic             abort_q, abort_n, underrun_q, underrun_n;

   // Bit 0 is the newest sample; the top bit is the previous synced value used for edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= '0;
         cs_sync  <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-1:0], bus.ntr_clk};
         cs_sync  <= {cs_sync[SYNC_STAGES-1:0], bus.ntr_cs1};
      end
   end

   assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES];
   assign cs_rise  = cs_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES];
   assign cs_fall  = ~cs_sync[SYNC_STAGES-1] & cs_sync[SYNC_STAGES];
   assign cnt_inc  = cnt + LEN_W'(1);

   always_comb begin
      state_n     = state;
      cmd_n       = cmd_q;
      cmd_valid_n = cmd_valid_q;
      byte_cnt_n  = byte_cnt;
      cnt_n       = cnt;
      len_n       = len;
      dout_n      = dout_q;
      oe_n        = oe_q;
      rd_req_n    = 1'b0;
      load_n      = rd_req_q;
      abort_n     = 1'b0;
      underrun_n  = underrun_q;
      // CS deassertion overrides every other event in the same cycle.
      if (cs_rise) begin
         state_n     = IDLE;
         oe_n        = 1'b0;
         dout_n      = 8'hFF;
         cmd_valid_n = 1'b0;
         load_n      = 1'b0;
         abort_n     = (state == CMD) || (state == WAIT_RSP) || (state == DATA);
      end else begin
         if (load_q) dout_n = bus.rd_data;
         unique case (state)
            IDLE: if (cs_fall) begin
               cnt_n      = '0;
               byte_cnt_n = '0;
               underrun_n = 1'b0;
               state_n    = CMD;
            end
            CMD: if (clk_rise) begin
               cmd_n      = {cmd_q[55:0], bus.ntr_din};
               byte_cnt_n = byte_cnt + 3'd1;
               if (byte_cnt == 3'd7) begin
                  cmd_valid_n = 1'b1;
                  state_n     = WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (clk_rise) underrun_n = 1'b1;
               if (bus.rsp_ack) begin
                  cmd_valid_n = 1'b0;
                  len_n       = bus.rsp_len;
                  if (bus.rsp_len == '0) begin
                     state_n = DONE;
                  end else begin
                     state_n  = DATA;
                     rd_req_n = 1'b1;
                     oe_n     = 1'b1;
                  end
               end
            end
            DATA: if (clk_rise) begin
               cnt_n = cnt_inc;
               if (cnt_inc < len) begin
                  rd_req_n = 1'b1;
               end else begin
                  oe_n    = 1'b0;
                  dout_n  = 8'hFF;
                  load_n  = 1'b0;
                  state_n = DONE;
               end
            end
            DONE: ;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         byte_cnt    <= '0;
         cnt         <= '0;
         len         <= '0;
         dout_q      <= 8'hFF;
         oe_q        <= 1'b0;
         rd_req_q    <= 1'b0;
         load_q      <= 1'b0;
         abort_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state       <= state_n;
         cmd_q       <= cmd_n;
         cmd_valid_q <= cmd_valid_n;
         byte_cnt    <= byte_cnt_n;
         cnt         <= cnt_n;
         len         <= len_n;
         dout_q      <= dout_n;
         oe_q        <= oe_n;
         rd_req_q    <= rd_req_n;
         load_q      <= load_n;
         abort_q     <= abort_n;
         underrun_q  <= underrun_n;
      end
   end

   assign bus.ntr_dout  = dout_q;
   assign bus.ntr_oe    = oe_q;
   assign bus.cmd       = cmd_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.rd_req    = rd_req_q;
   assign bus.abort     = abort_q;
   assign bus.underrun  = underrun_q;

`ifdef NTR_XFER_STATS_EN
   logic [15:0] xfer_q, err_q;
   logic        xfer_inc, err_inc;

   assign xfer_inc = (state_n == DONE) && (state != DONE);
   assign err_inc  = abort_n || (underrun_n && !underrun_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_q <= '0;
         err_q  <= '0;
      end else begin
         if (xfer_inc && (xfer_q != '1)) xfer_q <= xfer_q + 16'd1;
         if (err_inc && (err_q != '1))   err_q  <= err_q + 16'd1;
      end
   end

   assign bus.xfer_cnt = xfer_q;
   assign bus.err_cnt  = err_q;
`endif
endmodule

// File: tb/tb_ntr_bus_ctrl.sv
// Randomized scoreboard bench for ntr_bus_ctrl: a host driver pushes expected frames,
// bytes and aborts into queues; independent monitors pop and compare.
module tb_ntr_bus_ctrl;
   localparam int unsigned LEN_W = 13;
   localparam int unsigned SYNC  = 2;
   localparam int          HALF  = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ntr_bus_ctrl_if #(.LEN_W(LEN_W)) bus ();
   ntr_bus_ctrl #(.SYNC_STAGES(SYNC), .LEN_W(LEN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned rd_exp   = 0;
   int unsigned rd_req_cnt = 0;
`ifdef NTR_XFER_STATS_EN
   int unsigned xfer_model = 0;
   int unsigned err_model  = 0;
`endif

   logic [63:0] exp_cmd_q[$];
   logic [7:0]  exp_byte_q[$];
   bit          exp_abort_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Response byte source: returns its next byte one clk after each rd_req.
   logic [7:0] src_mem [256];
   logic [7:0] rd_ptr = 8'd0;
   always @(posedge clk) begin
      if (bus.rd_req) begin
         bus.rd_data <= src_mem[rd_ptr];
         rd_ptr      <= rd_ptr + 8'd1;
      end
   end

   logic cv_prev = 1'b0;
   always @(negedge clk) begin
      cv_prev <= bus.cmd_valid;
      if (rst_n) begin
         if (bus.rd_req) rd_req_cnt <= rd_req_cnt + 1;
         if (bus.cmd_valid && !cv_prev) begin
            if (exp_cmd_q.size() == 0) begin
               n_checks++;
               $display("FAIL cmd_valid: rose with no frame pending, cmd=%h", bus.cmd);
            end else begin
               chk("cmd", bus.cmd, exp_cmd_q.pop_front());
            end
         end
         if (bus.abort) begin
            n_checks++;
            if (exp_abort_q.size() == 0) $display("FAIL abort: pulse seen, none expected");
            else begin
               void'(exp_abort_q.pop_front());
               n_pass++;
            end
         end
      end
   end

   always @(posedge bus.ntr_clk) begin
      if (rst_n && bus.ntr_oe) begin
         if (exp_byte_q.size() == 0) begin
            n_checks++;
            $display("FAIL dout: oe high at ntr_clk rise, no byte expected (dout=%h)", bus.ntr_dout);
         end else begin
            chk("dout", {56'd0, bus.ntr_dout}, {56'd0, exp_byte_q.pop_front()});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_byte(input logic [7:0] d);
      bus.ntr_din = d;
      idle(HALF);
      bus.ntr_clk = 1'b1;
      idle(HALF);
      bus.ntr_clk = 1'b0;
   endtask

   task automatic end_cs(input bit expect_abort);
      if (expect_abort) begin
         exp_abort_q.push_back(1'b1);
`ifdef NTR_XFER_STATS_EN
         err_model++;
`endif
      end
      bus.ntr_cs1 = 1'b1;
      idle(10);
   endtask

   // ph: 0 complete, 1 abort after ab_n cmd bytes, 2 abort in WAIT_RSP,
   // 3 abort after ab_n data bytes, 4 async reset after ab_n data bytes.
   task automatic run_tx(input logic [63:0] c, input int n_under, input int len,
                         input int ph, input int ab_n, input bit seq_data);
      logic [7:0] base;
      int nr;
      bus.ntr_cs1 = 1'b0;
      idle(6);
      chk("underrun_clr", {63'd0, bus.underrun}, 64'd0);
      if (ph == 1) begin
         for (int i = 0; i < ab_n; i++) bus_byte(c[63-8*i -: 8]);
         end_cs(1'b1);
         return;
      end
      exp_cmd_q.push_back(c);
      for (int i = 0; i < 8; i++) bus_byte(c[63-8*i -: 8]);
      chk("cmd_valid_set", {63'd0, bus.cmd_valid}, 64'd1);
      for (int i = 0; i < n_under; i++) bus_byte(8'($urandom));
      if (n_under > 0) begin
         chk("underrun_set", {63'd0, bus.underrun}, 64'd1);
         chk("cmd_hold", bus.cmd, c);
`ifdef NTR_XFER_STATS_EN
         err_model++;
`endif
      end
      if (ph == 2) begin
         end_cs(1'b1);
         return;
      end
      base = rd_ptr;
      for (int k = 0; k < len; k++)
         src_mem[base + 8'(k)] = seq_data ? 8'hA0 + 8'(k) : 8'($urandom);
      bus.rsp_len = LEN_W'(len);
      bus.rsp_ack = 1'b1;
      idle(1);
      bus.rsp_ack = 1'b0;
      chk("cmd_valid_clr", {63'd0, bus.cmd_valid}, 64'd0);
      nr = (ph >= 3) ? ab_n : len;
      rd_exp += (ph >= 3) ? ab_n + 1 : len;
      for (int k = 0; k < nr; k++) begin
         exp_byte_q.push_back(src_mem[base + 8'(k)]);
         bus_byte(8'($urandom));
      end
      if (ph == 3) begin
         end_cs(1'b1);
         return;
      end
      if (ph == 4) begin
         #3 rst_n = 1'b0;
         #1;
         chk("rst_oe", {63'd0, bus.ntr_oe}, 64'd0);
         chk("rst_dout", {56'd0, bus.ntr_dout}, 64'hFF);
         chk("rst_cmd", bus.cmd, 64'd0);
         chk("rst_cmd_valid", {63'd0, bus.cmd_valid}, 64'd0);
`ifdef NTR_XFER_STATS_EN
         chk("rst_xfer_cnt", {48'd0, bus.xfer_cnt}, 64'd0);
         chk("rst_err_cnt", {48'd0, bus.err_cnt}, 64'd0);
         xfer_model = 0;
         err_model  = 0;
`endif
         bus.ntr_cs1 = 1'b1;
         idle(3);
         rst_n = 1'b1;
         idle(5);
         return;
      end
      chk("oe_done", {63'd0, bus.ntr_oe}, 64'd0);
      chk("dout_done", {56'd0, bus.ntr_dout}, 64'hFF);
`ifdef NTR_XFER_STATS_EN
      xfer_model++;
`endif
      end_cs(1'b0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] c;
      int len, nu, ph, an, r;
      bus.ntr_clk = 1'b0;
      bus.ntr_cs1 = 1'b1;
      bus.ntr_din = 8'h00;
      bus.rsp_ack = 1'b0;
      bus.rsp_len = '0;
      idle(3);
      chk("reset_dout", {56'd0, bus.ntr_dout}, 64'hFF);
      chk("reset_oe", {63'd0, bus.ntr_oe}, 64'd0);
      chk("reset_cmd", bus.cmd, 64'd0);
      chk("reset_cmd_valid", {63'd0, bus.cmd_valid}, 64'd0);
      chk("reset_rd_req", {63'd0, bus.rd_req}, 64'd0);
      chk("reset_abort", {63'd0, bus.abort}, 64'd0);
      chk("reset_underrun", {63'd0, bus.underrun}, 64'd0);
      rst_n = 1'b1;
      idle(5);

      run_tx(64'hFF00000000000000, 0, 0, 0, 0, 1'b0);
      chk("cmd_retained", bus.cmd, 64'hFF00000000000000);
      bus.rsp_len = LEN_W'(3);
      bus.rsp_ack = 1'b1;
      idle(1);
      bus.rsp_ack = 1'b0;
      idle(5);
      chk("ack_in_idle_oe", {63'd0, bus.ntr_oe}, 64'd0);
      idle(100);
      run_tx(64'hFF00000000000001, 0, 0, 0, 0, 1'b0);
      chk("cmd_second", bus.cmd, 64'hFF00000000000001);
      run_tx({$urandom, $urandom}, 0, 4, 0, 0, 1'b1);
      run_tx({$urandom, $urandom}, 0, 0, 1, 3, 1'b0);
      run_tx(64'h0123456789ABCDEF, 0, 2, 0, 0, 1'b0);
      run_tx({$urandom, $urandom}, 2, 2, 0, 0, 1'b0);

      for (int t = 0; t < 24; t++) begin
         r   = int'($urandom_range(0, 9));
         len = int'($urandom_range(0, 6));
         nu  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         c   = {$urandom, $urandom};
         ph  = 0;
         an  = 0;
         if (r == 0) begin
            ph = 1;
            an = int'($urandom_range(0, 7));
         end else if (r == 1) begin
            ph = 2;
         end else if (r == 2 && len > 0) begin
            ph = 3;
            an = int'($urandom_range(0, len - 1));
         end
         run_tx(c, nu, len, ph, an, 1'b0);
      end

`ifdef NTR_XFER_STATS_EN
      chk("xfer_cnt", {48'd0, bus.xfer_cnt}, 64'(xfer_model));
      chk("err_cnt", {48'd0, bus.err_cnt}, 64'(err_model));
`endif
      run_tx({$urandom, $urandom}, 0, 4, 4, 2, 1'b1);
      run_tx({$urandom, $urandom}, 0, 3, 0, 0, 1'b0);

      idle(20);
      chk("rd_req_total", 64'(rd_req_cnt), 64'(rd_exp));
      chk("cmd_q_drained", 64'(exp_cmd_q.size()), 64'd0);
      chk("byte_q_drained", 64'(exp_byte_q.size()), 64'd0);
      chk("abort_q_drained", 64'(exp_abort_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
